// File: rtl/dmem_bridge_pkg.sv
// Shared encodings for the CPU data-memory bridge and its byte-lane aligner.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // The reserved size code behaves as a word access.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables, replicated store data and
// right-aligned load data for a given access size and byte offset.
module dmem_lane_align
  import dmem_bridge_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = rdata_i >> {lane_i, 3'b000};
      end
      SZ_HALF: begin
        be_o    = BE_HALF << {lane_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = rdata_i >> {lane_i, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle DMEM port onto a wait-stated req/ack word bus,
// stalling the core until each access completes, times out or is rejected.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_read_wrn,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_halt,
  output logic              err_misalign,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYCLES);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              mem_req_q;
  logic [31:0]       cpu_rdata_q;
  logic              err_misalign_q;
  logic              err_timeout_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;

  logic              cpu_misalign;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;

  assign cpu_misalign = is_misaligned(size_e'(cpu_size), cpu_addr[1:0]);
  assign cnt_d        = cnt_q + 8'd1;

  dmem_lane_align u_lane_align (
    .size_i  (size_q),
    .lane_i  (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      size_q         <= SZ_BYTE;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      mem_req_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      cnt_q          <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            if (cpu_misalign) begin
              err_misalign_q <= 1'b1;
              cpu_rdata_q    <= '0;
              state_q        <= ST_DONE;
            end else begin
              addr_q    <= cpu_addr;
              size_q    <= size_e'(cpu_size);
              we_q      <= ~cpu_read_wrn;
              wdata_q   <= cpu_wdata;
              mem_req_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_d;
          // An ack arriving on the final permitted cycle still wins over the timeout.
          if (mem_ack) begin
            if (!we_q) cpu_rdata_q <= al_rdata;
            mem_req_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_d == TO_CNT) begin
            mem_req_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            cpu_rdata_q   <= '0;
            state_q       <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (err_clr) begin
        err_misalign_q <= 1'b0;
        err_timeout_q  <= 1'b0;
      end
    end
  end

  // Gated by rst_n so the stall also drops while reset is held with cpu_req high.
  assign cpu_halt = rst_n & (((state_q == ST_IDLE) & cpu_req & ~cpu_misalign)
                             | (state_q == ST_ACCESS));

  assign cpu_rdata    = cpu_rdata_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = we_q & mem_req_q;
  assign mem_addr     = addr_q[ADDR_W-1:2];
  assign mem_be       = mem_req_q ? al_be : 4'b0000;
  assign mem_wdata    = al_wdata;

endmodule
